// File: rtl/xentry_pkg.sv
// xentry_pkg: shared instruction-cache request and controller state types
package xentry_pkg;
  typedef enum logic {OP_FETCH, OP_FLUSH} icache_op_e;
  typedef enum logic [1:0] {IDLE, FILL, REFETCH} icache_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    count <= clear ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/icache_controller.sv
// icache_controller: fetch/flush handshake, hit service and L2 line-fill sequencing
module icache_controller
  import xentry_pkg::*;
#(
  parameter int LINE_SIZE  = 32,
  parameter int XLEN       = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_req_valid,
  input  icache_op_e            pipe_req_op,
  output logic                  pipe_req_fulfilled,
  output logic                  l2_req_valid,
  input  logic                  l2_req_fulfilled,
  output logic                  load_mode,
  output logic                  perform_write,
  output logic                  clear_selected_valid_bit,
  output logic                  finish_new_line_install,
  output logic                  set_new_l2_block_address,
  output logic                  reset_counter,
  output logic                  decrement_counter,
  input  logic                  counter_done,
  input  logic                  valid_block_match,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);
  if (XLEN != 32 || LINE_SIZE < 4 || LINE_SIZE % 4 != 0) begin : g_bad_cfg
    $error("icache_controller: only XLEN=32 with a word-multiple LINE_SIZE is supported");
  end
  icache_state_e state, state_n;
  logic hit_inc, miss_inc;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n                  = state;
    pipe_req_fulfilled       = 1'b0;
    l2_req_valid             = 1'b0;
    load_mode                = 1'b0;
    perform_write            = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    set_new_l2_block_address = 1'b0;
    reset_counter            = 1'b0;
    decrement_counter        = 1'b0;
    hit_inc                  = 1'b0;
    miss_inc                 = 1'b0;
    case (state)
      IDLE: if (pipe_req_valid) begin
        if (pipe_req_op == OP_FLUSH) begin
          clear_selected_valid_bit = 1'b1;
          pipe_req_fulfilled       = 1'b1;
        end else if (valid_block_match) begin
          pipe_req_fulfilled = 1'b1;
          hit_inc            = 1'b1;
        end else begin
          // valid bit is dropped now so an aborted fill never leaves a stale line
          set_new_l2_block_address = 1'b1;
          reset_counter            = 1'b1;
          clear_selected_valid_bit = 1'b1;
          miss_inc                 = 1'b1;
          state_n                  = FILL;
        end
      end
      FILL: begin
        load_mode    = 1'b1;
        l2_req_valid = 1'b1;
        if (l2_req_fulfilled) begin
          perform_write           = 1'b1;
          finish_new_line_install = counter_done;
          decrement_counter       = !counter_done;
          state_n                 = counter_done ? REFETCH : FILL;
        end
      end
      REFETCH: begin
        pipe_req_fulfilled = 1'b1;
        state_n            = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  sat_counter #(.WIDTH(STAT_WIDTH)) u_hit  (.clk(clk), .inc(hit_inc),  .clear(reset), .count(hit_count));
  sat_counter #(.WIDTH(STAT_WIDTH)) u_miss (.clk(clk), .inc(miss_inc), .clear(reset), .count(miss_count));
  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (pipe_req_valid && !pipe_req_fulfilled) |=> (!pipe_req_valid || $stable(pipe_req_op)));
  a_write_in_load: assert property (@(posedge clk) disable iff (reset) perform_write |-> load_mode);
  a_install_vs_clear: assert property (@(posedge clk) disable iff (reset)
    !(finish_new_line_install && clear_selected_valid_bit));
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: randomized scoreboard bench with a behavioural datapath, L2 and cache model
module tb_icache_controller;
  import xentry_pkg::*;
  logic clk = 0, reset = 1;
  logic pipe_req_valid = 0;
  icache_op_e pipe_req_op = OP_FETCH;
  logic [31:0] addr = 0;
  logic pipe_req_fulfilled, l2_req_valid, l2_req_fulfilled, load_mode, perform_write;
  logic clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address;
  logic reset_counter, decrement_counter, counter_done, valid_block_match;
  logic [15:0] hit_count, miss_count;
  logic [1:0] hit2, miss2;
  logic d_ful, d_l2v, d_lm, d_pw, d_clr, d_fin, d_set, d_rc, d_dec;

  always #5 clk = ~clk;

  icache_controller dut (
    .clk(clk), .reset(reset), .pipe_req_valid(pipe_req_valid), .pipe_req_op(pipe_req_op),
    .pipe_req_fulfilled(pipe_req_fulfilled), .l2_req_valid(l2_req_valid),
    .l2_req_fulfilled(l2_req_fulfilled), .load_mode(load_mode), .perform_write(perform_write),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install),
    .set_new_l2_block_address(set_new_l2_block_address), .reset_counter(reset_counter),
    .decrement_counter(decrement_counter), .counter_done(counter_done),
    .valid_block_match(valid_block_match), .hit_count(hit_count), .miss_count(miss_count));

  icache_controller #(.STAT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .pipe_req_valid(pipe_req_valid), .pipe_req_op(pipe_req_op),
    .pipe_req_fulfilled(d_ful), .l2_req_valid(d_l2v), .l2_req_fulfilled(l2_req_fulfilled),
    .load_mode(d_lm), .perform_write(d_pw), .clear_selected_valid_bit(d_clr),
    .finish_new_line_install(d_fin), .set_new_l2_block_address(d_set),
    .reset_counter(d_rc), .decrement_counter(d_dec), .counter_done(counter_done),
    .valid_block_match(valid_block_match), .hit_count(hit2), .miss_count(miss2));

  // behavioural datapath: 32 sets x 8 words, tag = addr[31:10]
  logic        vld [32];
  logic [21:0] tg  [32];
  logic [31:0] mem [32][8];
  logic [26:0] blk = 0;
  logic [2:0]  cnt = 0;
  int          l2_period = 1, fill_cyc = 0, cyc = 0;
  logic [31:0] l2_req_address;

  function automatic logic [31:0] l2_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign counter_done      = (cnt == 3'd0);
  assign valid_block_match = vld[addr[9:5]] && (tg[addr[9:5]] == addr[31:10]);
  assign l2_req_address    = {blk, cnt, 2'b00};
  assign l2_req_fulfilled  = l2_req_valid && ((fill_cyc % l2_period) == l2_period - 1);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    fill_cyc <= l2_req_valid ? fill_cyc + 1 : 0;
    if (set_new_l2_block_address) blk <= addr[31:5];
    if (reset_counter) cnt <= 3'd7;
    if (decrement_counter) cnt <= cnt - 3'd1;
    if (perform_write) mem[addr[9:5]][cnt] <= l2_word(l2_req_address);
    if (clear_selected_valid_bit) vld[addr[9:5]] <= 1'b0;
    if (finish_new_line_install) begin
      vld[addr[9:5]] <= 1'b1;
      tg[addr[9:5]]  <= addr[31:10];
    end
  end

  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    bit flush, hit;
    int period, issue, hits, misses;
  } exp_t;
  exp_t sb[$];
  logic [31:0] aq[$];
  logic [21:0] rtag[int];
  int ref_hits = 0, ref_misses = 0;
  bit mon_en = 1, chk_cnt = 0;
  int beats = 0;
  exp_t last;

  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction

  always @(negedge clk) if (!reset && mon_en) begin
    if (perform_write) begin
      chk("write_implies_load", load_mode, 1);
      if (aq.size() == 0) chk("unexpected_beat", 1, 0);
      else chk("l2_addr", l2_req_address, aq.pop_front());
      beats++;
    end
    if (finish_new_line_install) chk("install_and_clear", clear_selected_valid_bit, 0);
    if (chk_cnt) begin
      chk("hit_count", hit_count, last.hits);
      chk("miss_count", miss_count, last.misses);
      chk("hit_count_w2", hit2, sat(last.hits, 3));
      chk("miss_count_w2", miss2, sat(last.misses, 3));
      chk_cnt = 0;
    end
    if (pipe_req_fulfilled) begin
      if (sb.size() == 0) chk("spurious_fulfilled", 1, 0);
      else begin
        last = sb.pop_front();
        chk("latency", cyc - last.issue, (last.hit || last.flush) ? 0 : 8 * last.period + 1);
        chk("beats", beats, (last.hit || last.flush) ? 0 : 8);
        if (!last.flush) chk("data", mem[last.a[9:5]][last.a[4:2]], l2_word({last.a[31:2], 2'b00}));
        chk_cnt = 1;
      end
      beats = 0;
    end
  end

  // reference model: predicts hit/miss, beat addresses and counts from the cache rules
  task automatic predict(input logic [31:0] a, input bit fl, input int p);
    exp_t e;
    int s = int'(a[9:5]);
    e.a = a; e.flush = fl; e.period = p; e.issue = cyc;
    e.hit = !fl && rtag.exists(s) && rtag[s] == a[31:10];
    if (fl) rtag.delete(s);
    else if (e.hit) ref_hits++;
    else begin
      ref_misses++;
      rtag[s] = a[31:10];
      for (int w = 7; w >= 0; w--) aq.push_back({a[31:5], 3'(w), 2'b00});
    end
    e.hits = sat(ref_hits, 16'hFFFF);
    e.misses = sat(ref_misses, 16'hFFFF);
    sb.push_back(e);
  endtask

  task automatic req(input logic [31:0] a, input bit fl, input int p);
    int n = 0;
    addr = a; l2_period = p;
    pipe_req_op = fl ? OP_FLUSH : OP_FETCH;
    pipe_req_valid = 1;
    predict(a, fl, p);
    do begin
      @(negedge clk);
      n++;
    end while (!pipe_req_fulfilled && n < 200);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL timeout: no fulfilled for %0h after %0d cycles", a, n);
    end
    @(posedge clk); #1;
    pipe_req_valid = 0;
  endtask

  task automatic check_idle(input string n);
    chk({n, "_ful"}, pipe_req_fulfilled, 0);
    chk({n, "_l2v"}, l2_req_valid, 0);
    chk({n, "_load"}, load_mode, 0);
    chk({n, "_ctl"}, {perform_write, clear_selected_valid_bit, finish_new_line_install,
        set_new_l2_block_address, reset_counter, decrement_counter}, 0);
    chk({n, "_hits"}, hit_count, 0);
    chk({n, "_misses"}, miss_count, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) vld[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 0;
    req(32'h0000_1004, 0, 1);
    req(32'h0000_1008, 0, 1);
    req(32'h0000_1000, 1, 1);
    req(32'h0000_1000, 0, 1);
    req(32'h0000_1040, 0, 3);
    req(32'h0000_1000, 0, 2);
    req(32'h0000_1400, 0, 1);
    req(32'h0000_1000, 0, 1);
    // abort a fill with reset during its 4th beat
    mon_en = 0;
    addr = 32'h0000_1400; l2_period = 1; pipe_req_op = OP_FETCH; pipe_req_valid = 1;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (perform_write) n++;
    end
    chk("reset_beats_seen", n, 4);
    reset = 1; pipe_req_valid = 0;
    @(posedge clk); #1;
    check_idle("midfill_reset");
    reset = 0;
    ref_hits = 0; ref_misses = 0;
    rtag.delete(int'(addr[9:5]));
    aq.delete(); sb.delete(); beats = 0; chk_cnt = 0;
    @(posedge clk); #1;
    mon_en = 1;
    req(32'h0000_1400, 0, 1);
    for (int i = 0; i < 5; i++) req(32'h0000_1404 + 4 * i, 0, 1);
    for (int i = 0; i < 40; i++)
      req({20'h0, 2'($urandom_range(0, 2)) + 2'd1, 5'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'b00},
          $urandom_range(0, 4) == 0, $urandom_range(1, 3));
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
